// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-cycle wide adder/subtractor built around one shared N-bit
// carry-lookahead slice. A W = N*CHUNKS bit operation is stepped through the slice
// one chunk per cycle, LSB chunk first, with a 1-bit carry registered between chunks.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operation request          in_ready   high only while idle
//   a, b       W-bit two's-complement operands
//   sub        0: a+b, 1: a-b
//   out_valid  result available           out_ready  consumer accepts result
//   sum        W-bit registered result
//   cout       carry out of bit W-1 (subtract: 1 = no borrow)
//   ovf        signed overflow of the W-bit result
module cla_seq_adder #(
  parameter int unsigned N      = 16,
  parameter int unsigned CHUNKS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*CHUNKS-1:0] a,
  input  logic [N*CHUNKS-1:0] b,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*CHUNKS-1:0] sum,
  output logic                cout,
  output logic                ovf
);

  localparam int unsigned W  = N * CHUNKS;
  localparam int unsigned KW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [KW-1:0] KLast = KW'(CHUNKS - 1);

  // Shared N-bit carry-lookahead slice. Carries are expressed in generate/propagate
  // form, c[i+1] = g[i] | p[i]&c[i], which synthesis flattens into lookahead logic.
  function automatic logic [N:0] cla_slice(input logic [N-1:0] x,
                                           input logic [N-1:0] y,
                                           input logic         ci);
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < int'(N); i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[N], p ^ c[N-1:0]};
  endfunction

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;       // already inverted for subtract
  logic          carry_q, carry_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [N-1:0]  slice_a;
  logic [N-1:0]  slice_b;
  logic [N:0]    slice_res;
  logic [N-1:0]  slice_sum;
  logic          slice_cout;

  always_comb begin
    slice_a    = a_q[k_q*N +: N];
    slice_b    = b_q[k_q*N +: N];
    slice_res  = cla_slice(slice_a, slice_b, carry_q);
    slice_sum  = slice_res[N-1:0];
    slice_cout = slice_res[N];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          // Subtract is a + ~b + 1: the +1 enters as the initial carry.
          carry_d = sub;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[k_q*N +: N] = slice_sum;
        carry_d           = slice_cout;
        if (k_q == KLast) begin
          cout_d  = slice_cout;
          // Sign bits of the top chunk live at slice bit N-1.
          ovf_d   = slice_a[N-1] ^ slice_b[N-1] ^ slice_sum[N-1] ^ slice_cout;
          k_d     = '0;
          state_d = StDone;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
module tb_cla_seq_adder;

  localparam int unsigned N      = 16;
  localparam int unsigned CHUNKS = 4;
  localparam int unsigned W      = N * CHUNKS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.N(N), .CHUNKS(CHUNKS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain (W+1)-bit arithmetic, signed overflow from operand/result signs.
  function automatic vec_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    vec_t         r;
    logic [W:0]   full;
    logic [W-1:0] ye;
    ye     = s ? ~y : y;
    full   = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, s};
    r.a    = x;
    r.b    = y;
    r.sub  = s;
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (x[W-1] == ye[W-1]) && (full[W-1] != x[W-1]);
    return r;
  endfunction

  // Issue one op from idle, scramble inputs during RUN, check latency and result,
  // optionally stall out_ready for `stall` cycles. Entered and left at a negedge.
  task automatic run_op(input vec_t v, input int stall, input string tag);
    int           lat;
    logic [W-1:0] s0;
    logic         c0;
    logic         o0;
    in_valid = 1'b1;
    a        = v.a;
    b        = v.b;
    sub      = v.sub;
    chk({tag, " in_ready_before"}, W'(in_ready), W'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      sub = 1'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, " latency"}, W'(lat), W'(CHUNKS));
    chk({tag, " sum"}, sum, v.sum);
    chk({tag, " cout"}, W'(cout), W'(v.cout));
    chk({tag, " ovf"}, W'(ovf), W'(v.ovf));
    s0 = sum;
    c0 = cout;
    o0 = ovf;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, " stall_valid"}, W'(out_valid), W'(1));
      chk({tag, " stall_in_ready"}, W'(in_ready), W'(0));
      chk({tag, " stall_sum"}, sum, s0);
      chk({tag, " stall_flags"}, W'({cout, ovf}), W'({c0, o0}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " idle_after"}, W'({in_ready, out_valid}), W'(2'b10));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   acc_cyc[3];
    int   acc;
    int   res;
    int   cyc;
    vec_t ops[3];

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[4] = '{64'h5, 64'h3, 1'b1, 64'h2, 1'b1, 1'b0};
    vecs[5] = '{64'h0000_0000_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0,
                64'h0000_0001_0000_0000, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", W'(in_ready), W'(1));
    chk("reset out_valid", W'(out_valid), W'(0));
    chk("reset sum", sum, '0);
    chk("reset cout_ovf", W'({cout, ovf}), W'(0));
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i], (i == 0) ? 5 : 0, $sformatf("vec%0d", i));
    end

    // Reset mid-RUN at k=2 aborts the operation.
    in_valid = 1'b1;
    a        = 64'h1234_5678_9ABC_DEF0;
    b        = 64'h1111_1111_1111_1111;
    sub      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort in_ready", W'(in_ready), W'(1));
    chk("abort out_valid", W'(out_valid), W'(0));
    chk("abort sum", sum, '0);
    begin
      int seen = 0;
      repeat (8) begin
        @(posedge clk);
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("abort no_result", W'(seen), W'(0));
    end

    // Random ops with random backpressure.
    for (int i = 0; i < 12; i++) begin
      v = model({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      run_op(v, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    // Back-to-back with in_valid and out_ready held high.
    for (int i = 0; i < 3; i++) begin
      ops[i] = model({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    end
    acc       = 0;
    res       = 0;
    cyc       = 0;
    out_ready = 1'b1;
    while (res < 3 && cyc < 60) begin
      if (out_valid) begin
        chk($sformatf("b2b%0d sum", res), sum, ops[res].sum);
        chk($sformatf("b2b%0d flags", res), W'({cout, ovf}), W'({ops[res].cout, ops[res].ovf}));
        res++;
      end
      if (in_ready && acc < 3) begin
        in_valid     = 1'b1;
        a            = ops[acc].a;
        b            = ops[acc].b;
        sub          = ops[acc].sub;
        acc_cyc[acc] = cyc;
        acc++;
      end else if (in_ready) begin
        in_valid = 1'b0;
      end else begin
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        sub = 1'($urandom);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b results", W'(res), W'(3));
    chk("b2b accepts", W'(acc), W'(3));
    chk("b2b spacing01", W'(acc_cyc[1] - acc_cyc[0]), W'(CHUNKS + 2));
    chk("b2b spacing12", W'(acc_cyc[2] - acc_cyc[1]), W'(CHUNKS + 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
